// File: rtl/kbd_rx_fifo.sv
// kbd_rx_fifo: receive-side byte queue between the UART receiver and the
// LC-3 keyboard registers. Received bytes are buffered in a circular FIFO and
// handed to the datapath one at a time through the KBDR/KBSR load ports. A new
// byte is only presented after the program has cleared KBSR[15].
//
// Optional feature: define KBD_RX_FIFO_OVF_CNT_EN to build a saturating 8-bit
// dropped-byte counter on o_ovf_cnt; otherwise o_ovf_cnt is tied to zero.
module kbd_rx_fifo #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_Clk,
    input  logic          reset,
    input  logic          i_Rx_DV,
    input  logic [7:0]    i_Rx_Byte,
    output logic          o_Rx_Enable,
    input  logic [15:0]   kbsr,
    output logic          o_ld_kbdr_ext,
    output logic [15:0]   o_kbdr_ext,
    output logic          o_ld_kbsr_ext,
    output logic [15:0]   o_kbsr_ext,
    output logic [AW:0]   o_count,
    output logic          o_overflow,
    output logic [7:0]    o_ovf_cnt
);

    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   EMPTY_CNT = (AW+1)'(0);
    localparam logic [AW:0]   ONE_CNT   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR   = AW'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_SET = 2'd2,
        WAIT_CLR = 2'd3
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;

    logic          full;
    logic          push;
    logic          drop;
    logic          pop;
    logic          unused_kbsr_bits;

    // Only the ready bit of KBSR matters; the rest is folded away.
    assign unused_kbsr_bits = ^kbsr[14:0];

    // Fullness is judged on the registered count, so a push in the pop cycle
    // of a full FIFO is still dropped.
    always_comb begin
        full = (cnt == FULL_CNT);
        push = i_Rx_DV && !full;
        drop = i_Rx_DV && full;
        pop  = (state == LOAD);
    end

    assign o_Rx_Enable = !full;
    assign o_count     = cnt;
    assign o_kbsr_ext  = 16'h8000;

    // Byte storage; contents are deliberately left unreset.
    always_ff @(posedge i_Clk) begin
        if (push && !reset) begin
            mem[wp] <= i_Rx_Byte;
        end
    end

    // Write/read pointers and occupancy, updated together for push and pop.
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            wp  <= {AW{1'b0}};
            rp  <= {AW{1'b0}};
            cnt <= EMPTY_CNT;
        end else begin
            if (push) begin
                wp <= wp + ONE_PTR;
            end else begin
                wp <= wp;
            end
            if (pop) begin
                rp <= rp + ONE_PTR;
            end else begin
                rp <= rp;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + ONE_CNT;
                2'b01:   cnt <= cnt - ONE_CNT;
                default: cnt <= cnt;
            endcase
        end
    end

    // Delivery FSM: load one byte, then wait for the datapath to set and the
    // program to clear KBSR[15] before offering the next byte.
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            state         <= IDLE;
            o_ld_kbdr_ext <= 1'b0;
            o_ld_kbsr_ext <= 1'b0;
            o_kbdr_ext    <= 16'h0000;
        end else begin
            o_ld_kbdr_ext <= 1'b0;
            o_ld_kbsr_ext <= 1'b0;
            case (state)
                IDLE: begin
                    if (cnt != EMPTY_CNT) begin
                        state         <= LOAD;
                        o_ld_kbdr_ext <= 1'b1;
                        o_ld_kbsr_ext <= 1'b1;
                        o_kbdr_ext    <= {8'h00, mem[rp]};
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    state <= WAIT_SET;
                end
                WAIT_SET: begin
                    if (kbsr[15]) begin
                        state <= WAIT_CLR;
                    end else begin
                        state <= WAIT_SET;
                    end
                end
                WAIT_CLR: begin
                    if (!kbsr[15]) begin
                        state <= IDLE;
                    end else begin
                        state <= WAIT_CLR;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky overflow flag: any dropped byte sets it until reset.
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else begin
            o_overflow <= o_overflow;
        end
    end

`ifdef KBD_RX_FIFO_OVF_CNT_EN
    // Saturating count of dropped bytes.
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            o_ovf_cnt <= 8'h00;
        end else if (drop && (o_ovf_cnt != 8'hFF)) begin
            o_ovf_cnt <= o_ovf_cnt + 8'h01;
        end else begin
            o_ovf_cnt <= o_ovf_cnt;
        end
    end
`else
    assign o_ovf_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_kbd_rx_fifo.sv
// Self-checking bench for kbd_rx_fifo (DEPTH=4). A queue-based reference
// model tracks accepted bytes, occupancy and drops; a small datapath/program
// model drives kbsr (echoing loads, clearing after a read).
module tb_kbd_rx_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          i_Clk = 1'b0;
    logic          reset;
    logic          i_Rx_DV;
    logic [7:0]    i_Rx_Byte;
    logic          o_Rx_Enable;
    logic [15:0]   kbsr;
    logic          o_ld_kbdr_ext;
    logic [15:0]   o_kbdr_ext;
    logic          o_ld_kbsr_ext;
    logic [15:0]   o_kbsr_ext;
    logic [AW:0]   o_count;
    logic          o_overflow;
    logic [7:0]    o_ovf_cnt;

    always #5 i_Clk = ~i_Clk;

    kbd_rx_fifo #(.DEPTH(DEPTH)) dut (
        .i_Clk         (i_Clk),
        .reset         (reset),
        .i_Rx_DV       (i_Rx_DV),
        .i_Rx_Byte     (i_Rx_Byte),
        .o_Rx_Enable   (o_Rx_Enable),
        .kbsr          (kbsr),
        .o_ld_kbdr_ext (o_ld_kbdr_ext),
        .o_kbdr_ext    (o_kbdr_ext),
        .o_ld_kbsr_ext (o_ld_kbsr_ext),
        .o_kbsr_ext    (o_kbsr_ext),
        .o_count       (o_count),
        .o_overflow    (o_overflow),
        .o_ovf_cnt     (o_ovf_cnt)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  q[$];
    int          mcnt = 0;
    int          drops = 0;
    bit          awaiting = 1'b0;
    bit          echo = 1'b1;
    bit          auto_clear = 1'b0;
    bit          prev_strobe = 1'b0;
    int          set_age = 0;
    int          wait_ticks = 0;
    logic [15:0] last_kbdr = 16'h0000;

    function automatic int exp_ovf();
`ifdef KBD_RX_FIFO_OVF_CNT_EN
        return (drops > 255) ? 255 : drops;
`else
        return 0;
`endif
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model for the edge, then compare DUT outputs.
    task automatic tick();
        logic       dv_pre;
        logic       rst_pre;
        logic       ld_pre;
        logic [7:0] byte_pre;
        logic       strobe;
        dv_pre   = i_Rx_DV;
        rst_pre  = reset;
        ld_pre   = o_ld_kbsr_ext;
        byte_pre = i_Rx_Byte;
        @(posedge i_Clk);
        #1;
        if (rst_pre) begin
            q.delete();
            mcnt = 0; drops = 0; awaiting = 1'b0; wait_ticks = 0;
            set_age = 0; last_kbdr = 16'h0000; prev_strobe = 1'b0;
        end else begin
            if (dv_pre) begin
                if (mcnt < DEPTH) begin
                    q.push_back(byte_pre);
                    mcnt++;
                end else begin
                    drops++;
                end
            end
            if (ld_pre === 1'b1) mcnt--;
            if (echo && ld_pre === 1'b1) begin
                kbsr = 16'h8000;
                set_age = 0;
            end else if (kbsr[15]) begin
                set_age++;
            end
        end
        strobe = o_ld_kbdr_ext;
        check("ld_pair", {31'd0, o_ld_kbsr_ext}, {31'd0, strobe});
        check("kbsr_val", {16'd0, o_kbsr_ext}, 32'h0000_8000);
        check("count", {29'd0, o_count}, mcnt);
        check("rx_en", {31'd0, o_Rx_Enable}, {31'd0, (mcnt != DEPTH)});
        check("ovf_flag", {31'd0, o_overflow}, {31'd0, (drops != 0)});
        check("ovf_cnt", {24'd0, o_ovf_cnt}, exp_ovf());
        if (strobe === 1'b1) begin
            check("ld_gap", {31'd0, awaiting}, 32'd0);
            check("ld_width", {31'd0, prev_strobe}, 32'd0);
            if (q.size() == 0) begin
                check("ld_empty", 32'd1, 32'd0);
            end else begin
                last_kbdr = {8'h00, q.pop_front()};
                check("kbdr", {16'd0, o_kbdr_ext}, {16'd0, last_kbdr});
            end
            awaiting   = 1'b1;
            wait_ticks = 0;
        end else begin
            check("kbdr_hold", {16'd0, o_kbdr_ext}, {16'd0, last_kbdr});
            if (!awaiting && q.size() > 0) wait_ticks++;
            else wait_ticks = 0;
            check("latency", {31'd0, (wait_ticks <= 1)}, 32'd1);
        end
        prev_strobe = (strobe === 1'b1);
        if (auto_clear && awaiting && kbsr[15] && set_age >= 1 &&
            $urandom_range(0, 2) == 0) begin
            kbsr = 16'h0000;
            awaiting = 1'b0;
        end
    endtask

    task automatic push(logic [7:0] b);
        i_Rx_DV = 1'b1;
        i_Rx_Byte = b;
        tick();
        i_Rx_DV = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic prog_clear();
        kbsr = 16'h0000;
        awaiting = 1'b0;
    endtask

    task automatic drain(int budget);
        auto_clear = 1'b1;
        echo = 1'b1;
        for (int i = 0; i < budget && (q.size() != 0 || awaiting); i++) tick();
        check("drain_done", {31'd0, (q.size() == 0 && !awaiting)}, 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        reset = 1'b1; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00; kbsr = 16'h0000;

        // Reset state
        do_reset();
        tick();
        check("rst_count", {29'd0, o_count}, 32'd0);
        check("rst_rx_en", {31'd0, o_Rx_Enable}, 32'd1);
        check("rst_kbdr", {16'd0, o_kbdr_ext}, 32'd0);
        check("rst_ld", {31'd0, o_ld_kbdr_ext}, 32'd0);

        // Single byte with minimum latency; FSM parks until kbsr is cleared
        echo = 1'b1; auto_clear = 1'b0;
        push(8'h41);
        check("lat_n", {31'd0, o_ld_kbdr_ext}, 32'd0);
        tick();
        check("lat_n1", {31'd0, o_ld_kbdr_ext}, 32'd1);
        check("single_kbdr", {16'd0, o_kbdr_ext}, 32'h0041);
        for (int i = 0; i < 6; i++) tick();
        check("single_park", {29'd0, o_count}, 32'd0);
        prog_clear();
        for (int i = 0; i < 4; i++) tick();

        // Ordering and pointer wrap
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            auto_clear = 1'b1;
            push(8'(i));
            for (int j = 0; j < 8; j++) tick();
        end
        drain(50);
        check("order_noloss", {31'd0, o_overflow}, 32'd0);

        // Simultaneous push and pop
        kbsr = 16'h0000; auto_clear = 1'b0; echo = 1'b1;
        do_reset();
        push(8'hA5);
        tick();
        check("simul_load", {31'd0, o_ld_kbdr_ext}, 32'd1);
        push(8'h5A);
        check("simul_cnt", {29'd0, o_count}, 32'd1);
        for (int i = 0; i < 3; i++) tick();
        prog_clear();
        tick();
        tick();
        check("simul_next_ld", {31'd0, o_ld_kbdr_ext}, 32'd1);
        check("simul_next", {16'd0, o_kbdr_ext}, 32'h005A);
        drain(50);

        // Reset mid-handshake in WAIT_SET with three bytes queued
        kbsr = 16'h0000; echo = 1'b0; auto_clear = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        check("mid_cnt3", {29'd0, o_count}, 32'd3);
        do_reset();
        check("mid_count", {29'd0, o_count}, 32'd0);
        check("mid_ld", {31'd0, o_ld_kbdr_ext}, 32'd0);
        check("mid_kbdr", {16'd0, o_kbdr_ext}, 32'd0);
        check("mid_rx_en", {31'd0, o_Rx_Enable}, 32'd1);
        kbsr = 16'h8000; tick(); tick();
        kbsr = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_no_ld", {31'd0, o_ld_kbdr_ext}, 32'd0);
        end

        // Overflow with kbsr[15] held high, then saturation of the counter
        kbsr = 16'h8000; echo = 1'b1; auto_clear = 1'b0;
        do_reset();
        i_Rx_DV = 1'b1;
        for (int i = 0; i < 7; i++) begin
            i_Rx_Byte = 8'h20 + 8'(i);
            tick();
        end
        i_Rx_DV = 1'b0;
        check("ovf_count4", {29'd0, o_count}, 32'd4);
        check("ovf_rx_en0", {31'd0, o_Rx_Enable}, 32'd0);
        check("ovf_flag1", {31'd0, o_overflow}, 32'd1);
`ifdef KBD_RX_FIFO_OVF_CNT_EN
        check("ovf_cnt2", {24'd0, o_ovf_cnt}, 32'd2);
`else
        check("ovf_cnt0", {24'd0, o_ovf_cnt}, 32'd0);
`endif
        i_Rx_DV = 1'b1;
        for (int i = 0; i < 298; i++) begin
            i_Rx_Byte = 8'($urandom);
            tick();
        end
        i_Rx_DV = 1'b0;
`ifdef KBD_RX_FIFO_OVF_CNT_EN
        check("ovf_sat", {24'd0, o_ovf_cnt}, 32'hFF);
`else
        check("ovf_sat_off", {24'd0, o_ovf_cnt}, 32'd0);
`endif
        drain(100);

        // Randomized traffic against the reference model
        kbsr = 16'h0000;
        do_reset();
        echo = 1'b1; auto_clear = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            b = 8'($urandom);
            i_Rx_DV = ($urandom_range(0, 3) == 0);
            i_Rx_Byte = b;
            tick();
        end
        i_Rx_DV = 1'b0;
        drain(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
